// File: rtl/mem_access_unit.sv
// mem_access_unit: 16-bit word memory access sequencer for narrow and wide (two-beat) loads/stores
// Optional range check enabled by defining MEM_ACCESS_ADDR_CHECK_EN.
module mem_access_unit #(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [15:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_data_out
);
`ifdef MEM_ACCESS_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t      state_q, state_d;
  logic        write_q, write_d, wide_q, wide_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        fault, beat;
  // Second comparison is addr+1 >= DEPTH without the 32-bit wrap hazard
  assign fault = CHECK_EN && (req_addr >= DEPTH || (req_wide && req_addr >= DEPTH - 32'd1));
  assign beat        = state_q == BEAT0 || state_q == BEAT1;
  assign req_ready   = state_q == IDLE;
  assign mem_read    = beat && !write_q;
  assign mem_write   = beat && write_q;
  assign mem_address = state_q == BEAT0 ? addr_q : state_q == BEAT1 ? addr_q + 32'd1 : '0;
  assign mem_data_in = mem_write ? ((state_q == BEAT0 && wide_q) ? wdata_q[31:16] : wdata_q[15:0]) : '0;
  assign rsp_valid   = state_q == RESP;
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_err     = rsp_valid && err_q;
  // Next state, request latching and load-data capture at the end of each read beat
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    wide_d  = wide_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = fault ? RESP : BEAT0;
        write_d = req_write;
        wide_d  = req_wide;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = fault;
      end
      BEAT0: begin
        state_d = wide_q ? BEAT1 : RESP;
        if (!write_q) rdata_d = wide_q ? {mem_data_out, 16'h0} : {16'h0, mem_data_out};
      end
      BEAT1: begin
        state_d = RESP;
        if (!write_q) rdata_d[15:0] = mem_data_out;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and latched request registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wide_q  <= wide_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule
